// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_DONE
  } arb_state_t;

  localparam int LEN_MIN        = 5;
  localparam int LEN_MAX        = 8;
  localparam int DEF_START_HOLD = 16;
  localparam int DEF_TIMEOUT    = 4096;

  // Counter width able to hold the larger of two terminal counts without wrapping.
  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after last_grant wins.
module rr_picker #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic            valid,
  output logic [IW-1:0]   winner
);

  // Walk the ring from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(last_grant) + k) % NREQ]) begin
        valid  = 1'b1;
        winner = IW'((int'(last_grant) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates NREQ frame requesters onto one UART transmitter, with
// start-strobe stretching, length screening and a completion timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int START_HOLD = DEF_START_HOLD,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [4*NREQ-1:0] req_len,
  input  logic [NREQ-1:0]   req_par_en,
  input  logic [NREQ-1:0]   req_par_type,
  input  logic [NREQ-1:0]   req_stop2,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   err,
  output logic              busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [3:0]        length,
  output logic              parity_en,
  output logic              parity_type,
  output logic              stop2,
  input  logic              tx_done,
  input  logic              tx_err
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = cnt_width(START_HOLD, TIMEOUT);

  arb_state_t      state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [IW-1:0]   winner, last_grant, pick;
  logic            pick_vld;
  logic            flag, flag_n;
  logic [3:0]      sel_len;
  logic            len_ok;

  rr_picker #(.NREQ(NREQ)) u_pick (
    .req        (req),
    .last_grant (last_grant),
    .valid      (pick_vld),
    .winner     (pick)
  );

  assign sel_len = req_len[4*int'(winner) +: 4];
  assign len_ok  = (sel_len >= 4'(LEN_MIN)) && (sel_len <= 4'(LEN_MAX));

  // cnt is shared by START (hold length) and WAIT (timeout); it restarts at 0
  // on every state change because cnt_n defaults to zero.
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    flag_n  = flag;
    unique case (state)
      S_IDLE: if (pick_vld) state_n = S_LOAD;
      S_LOAD: begin
        if (len_ok) begin
          state_n = S_START;
          flag_n  = 1'b0;
        end else begin
          state_n = S_DONE;
          flag_n  = 1'b1;
        end
      end
      S_START: begin
        if (cnt == CW'(START_HOLD - 1)) state_n = S_WAIT;
        else                            cnt_n   = cnt + CW'(1);
      end
      S_WAIT: begin
        if (tx_done) begin
          state_n = S_DONE;
          flag_n  = tx_err;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_n = S_DONE;
          flag_n  = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      flag        <= 1'b0;
      winner      <= '0;
      last_grant  <= IW'(NREQ - 1);
      tx_data     <= '0;
      length      <= '0;
      parity_en   <= 1'b0;
      parity_type <= 1'b0;
      stop2       <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      flag  <= flag_n;
      if (state == S_IDLE && pick_vld) winner <= pick;
      if (state == S_LOAD) begin
        tx_data     <= req_data[8*int'(winner) +: 8];
        length      <= sel_len;
        parity_en   <= req_par_en[winner];
        parity_type <= req_par_type[winner];
        stop2       <= req_stop2[winner];
      end
      if (state == S_DONE) last_grant <= winner;
    end
  end

  assign busy     = (state != S_IDLE);
  assign tx_start = (state == S_START);
  assign ack      = (state == S_DONE)         ? (NREQ'(1) << winner) : '0;
  assign err      = (state == S_DONE && flag) ? (NREQ'(1) << winner) : '0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a small transmitter responder.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int SH   = 16;
  localparam int TO   = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [4*NREQ-1:0] req_len = '0;
  logic [NREQ-1:0]   req_par_en = '0, req_par_type = '0, req_stop2 = '0;
  logic [NREQ-1:0]   ack, err;
  logic              busy, tx_start, parity_en, parity_type, stop2;
  logic [7:0]        tx_data;
  logic [3:0]        length;
  logic              tx_done = 1'b0, tx_err = 1'b0;

  uart_tx_arbiter #(.NREQ(NREQ), .START_HOLD(SH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_len(req_len),
    .req_par_en(req_par_en), .req_par_type(req_par_type), .req_stop2(req_stop2),
    .ack(ack), .err(err), .busy(busy), .tx_start(tx_start), .tx_data(tx_data),
    .length(length), .parity_en(parity_en), .parity_type(parity_type), .stop2(stop2),
    .tx_done(tx_done), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic       err;
    logic [7:0] data;
    logic [3:0] len;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0, checks = 0;
  int   cyc = 0;
  int   lg_model = NREQ - 1;

  always @(posedge clk) cyc <= cyc + 1;

  // Responder: pulses tx_done resp_delay cycles after tx_start falls (-1 = never).
  int   resp_delay = -1;
  logic tx_err_val = 1'b0;
  logic stray = 1'b0;
  initial begin
    int   cnt_d;
    logic prev_start;
    cnt_d = -1;
    prev_start = 1'b0;
    forever begin
      @(posedge clk); #1;
      tx_done = 1'b0;
      tx_err  = 1'b0;
      if (rst) cnt_d = -1;
      if (stray) begin
        tx_done = 1'b1;
        tx_err  = 1'b1;
        stray   = 1'b0;
      end
      if (prev_start && !tx_start && resp_delay >= 0) cnt_d = resp_delay;
      if (cnt_d == 0) begin
        tx_done = 1'b1;
        tx_err  = tx_err_val;
        cnt_d   = -1;
      end else if (cnt_d > 0) begin
        cnt_d--;
      end
      prev_start = tx_start;
    end
  end

  // tx_start run-length and pulse counter.
  int run = 0, last_run = 0, starts = 0;
  initial forever begin
    @(posedge clk); #1;
    if (tx_start) begin
      run++;
      if (run == 1) starts++;
    end else begin
      if (run > 0) last_run = run;
      run = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  function automatic int rr(input logic [NREQ-1:0] r, input int lg);
    for (int k = 1; k <= NREQ; k++)
      if (r[(lg + k) % NREQ]) return (lg + k) % NREQ;
    return -1;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input logic [3:0] l,
                         input logic pe, input logic pt, input logic s2);
    req_data[8*i +: 8] = d;
    req_len[4*i +: 4]  = l;
    req_par_en[i]      = pe;
    req_par_type[i]    = pt;
    req_stop2[i]       = s2;
  endtask

  task automatic push(input int i, input logic e, input int lat);
    exp_t x;
    x.idx  = i;
    x.err  = e;
    x.data = req_data[8*i +: 8];
    x.len  = req_len[4*i +: 4];
    x.lat  = lat;
    sb.push_back(x);
  endtask

  task automatic wait_ack(input int budget, output logic to);
    to = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (ack != '0) begin
        to = 1'b0;
        break;
      end
      tick();
    end
    if (ack != '0) to = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    tick(2);
    checks++; if (ack !== '0)       begin errors++; $display("FAIL reset_ack: got %0h want 0", ack); end
    checks++; if (err !== '0)       begin errors++; $display("FAIL reset_err: got %0h want 0", err); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %0b want 0", tx_start); end
    checks++; if ({tx_data, length, parity_en, parity_type, stop2} !== 15'h0)
      begin errors++; $display("FAIL reset_cfg: got %0h/%0h/%0b%0b%0b want 0", tx_data, length, parity_en, parity_type, stop2); end
    rst = 1'b0;
    lg_model = NREQ - 1;
    tick();
  endtask

  // One frame; a stray tx_done during START must not disturb it.
  task automatic test_single();
    exp_t e; logic to; int t0, lat;
    set_req(0, 8'hA5, 4'd8, 1'b1, 1'b0, 1'b1);
    resp_delay = 4; tx_err_val = 1'b0;
    push(rr(4'b0001, lg_model), 1'b0, 2 + SH + 5);
    t0 = cyc;
    req = 4'b0001;
    tick(5);
    stray = 1'b1;
    wait_ack(200, to);
    lat = cyc - t0;
    e = sb.pop_front();
    checks++; if (to) begin errors++; $display("FAIL single_timeout: no ack within budget"); end
    checks++; if (ack !== 4'(1 << e.idx)) begin errors++; $display("FAIL single_ack: got %0h want %0h", ack, 4'(1 << e.idx)); end
    checks++; if (err !== '0) begin errors++; $display("FAIL single_err: got %0h want 0", err); end
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL single_latency: got %0d want %0d", lat, e.lat); end
    checks++; if (tx_data !== e.data || length !== e.len)
      begin errors++; $display("FAIL single_cfg: got %0h/%0d want %0h/%0d", tx_data, length, e.data, e.len); end
    checks++; if ({parity_en, parity_type, stop2} !== 3'b101)
      begin errors++; $display("FAIL single_opts: got %b want 101", {parity_en, parity_type, stop2}); end
    checks++; if (last_run !== SH) begin errors++; $display("FAIL single_start_len: got %0d want %0d", last_run, SH); end
    lg_model = e.idx;
    req = '0;
    tick();
    checks++; if (ack !== '0) begin errors++; $display("FAIL single_ack_pulse: got %0h want 0", ack); end
    stray = 1'b1;
    tick(3);
    checks++; if (busy !== 1'b0 || ack !== '0)
      begin errors++; $display("FAIL idle_stray_done: got busy=%0b ack=%0h want 0/0", busy, ack); end
  endtask

  // Illegal length: no tx_start, ack+err in the third cycle counting the req cycle.
  task automatic test_len_err();
    exp_t e; logic to; int t0, lat, s0;
    set_req(2, 8'h3C, 4'd3, 1'b0, 1'b0, 1'b0);
    push(rr(4'b0100, lg_model), 1'b1, 2);
    s0 = starts; t0 = cyc;
    req = 4'b0100;
    wait_ack(50, to);
    lat = cyc - t0;
    e = sb.pop_front();
    checks++; if (to) begin errors++; $display("FAIL len_timeout: no ack within budget"); end
    checks++; if (ack !== 4'(1 << e.idx) || err !== 4'(1 << e.idx))
      begin errors++; $display("FAIL len_ack_err: got %0h/%0h want %0h/%0h", ack, err, 4'(1 << e.idx), 4'(1 << e.idx)); end
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL len_latency: got %0d want %0d", lat, e.lat); end
    checks++; if (starts !== s0) begin errors++; $display("FAIL len_no_start: got %0d starts want %0d", starts, s0); end
    lg_model = e.idx;
    req = '0;
    tick();
  endtask

  task automatic test_round_robin();
    exp_t e; logic to;
    rst = 1'b1; tick(2); rst = 1'b0;
    lg_model = NREQ - 1;
    for (int i = 0; i < NREQ; i++) set_req(i, 8'h10 + 8'(i), 4'(5 + i), 1'b0, 1'b1, 1'b0);
    resp_delay = 1; tx_err_val = 1'b0;
    req = '1;
    for (int n = 0; n < 5; n++) begin
      push(rr(req, lg_model), 1'b0, 0);
      wait_ack(100, to);
      e = sb.pop_front();
      checks++; if (to) begin errors++; $display("FAIL rr_timeout: grant %0d no ack", n); end
      checks++; if (ack !== 4'(1 << e.idx) || tx_data !== e.data)
        begin errors++; $display("FAIL rr_order: grant %0d got ack=%0h data=%0h want %0h/%0h", n, ack, tx_data, 4'(1 << e.idx), e.data); end
      lg_model = e.idx;
      tick();
      checks++; if (ack !== '0) begin errors++; $display("FAIL rr_ack_pulse: grant %0d got %0h want 0", n, ack); end
    end
    req = '0;
    tick();
  endtask

  task automatic test_tx_err();
    exp_t e; logic to; int t0, lat;
    resp_delay = 2; tx_err_val = 1'b1;
    push(rr(4'b0010, lg_model), 1'b1, 0);
    req = 4'b0010;
    wait_ack(200, to);
    e = sb.pop_front();
    checks++; if (to || ack !== 4'(1 << e.idx) || err !== 4'(1 << e.idx))
      begin errors++; $display("FAIL txerr_flag: got ack=%0h err=%0h want %0h/%0h", ack, err, 4'(1 << e.idx), 4'(1 << e.idx)); end
    lg_model = e.idx;
    req = '0;
    tick();
    // tx_done lands in the last WAIT cycle, together with the timeout expiry.
    resp_delay = TO - 1; tx_err_val = 1'b0;
    push(rr(4'b0010, lg_model), 1'b0, 2 + SH + TO);
    t0 = cyc;
    req = 4'b0010;
    wait_ack(TO + 100, to);
    lat = cyc - t0;
    e = sb.pop_front();
    checks++; if (to || err !== '0 || ack !== 4'(1 << e.idx))
      begin errors++; $display("FAIL done_vs_timeout: got ack=%0h err=%0h want %0h/0", ack, err, 4'(1 << e.idx)); end
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL done_vs_timeout_lat: got %0d want %0d", lat, e.lat); end
    lg_model = e.idx;
    req = '0;
    tick();
  endtask

  task automatic test_timeout();
    exp_t e; logic to; int t0, lat;
    resp_delay = -1;
    push(rr(4'b1001, lg_model), 1'b1, 2 + SH + TO);
    t0 = cyc;
    req = 4'b1001;
    wait_ack(TO + 100, to);
    lat = cyc - t0;
    e = sb.pop_front();
    checks++; if (to || ack !== 4'(1 << e.idx) || err !== 4'(1 << e.idx))
      begin errors++; $display("FAIL timeout_flag: got ack=%0h err=%0h want %0h/%0h", ack, err, 4'(1 << e.idx), 4'(1 << e.idx)); end
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL timeout_lat: got %0d want %0d", lat, e.lat); end
    lg_model = e.idx;
    req[e.idx] = 1'b0;
    resp_delay = 0;
    tick();
    push(rr(req, lg_model), 1'b0, 2 + SH + 1);
    t0 = cyc;
    wait_ack(200, to);
    lat = cyc - t0;
    e = sb.pop_front();
    checks++; if (to || ack !== 4'(1 << e.idx) || err !== '0 || lat !== e.lat)
      begin errors++; $display("FAIL timeout_next: got ack=%0h err=%0h lat=%0d want %0h/0/%0d", ack, err, lat, 4'(1 << e.idx), e.lat); end
    lg_model = e.idx;
    req = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    exp_t e; logic to; int seen;
    resp_delay = -1;
    req = 4'b0100;
    tick(SH + 6);
    rst = 1'b1;
    tick();
    checks++; if (ack !== '0 || err !== '0 || busy !== 1'b0 || tx_start !== 1'b0)
      begin errors++; $display("FAIL midrst_ctrl: got ack=%0h err=%0h busy=%0b start=%0b want 0", ack, err, busy, tx_start); end
    checks++; if ({tx_data, length, parity_en, parity_type, stop2} !== 15'h0)
      begin errors++; $display("FAIL midrst_cfg: got %0h/%0h want 0", tx_data, length); end
    rst = 1'b0;
    req = '0;
    lg_model = NREQ - 1;
    seen = 0;
    for (int c = 0; c < TO + 5; c++) begin
      tick();
      if (ack != '0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_ack: got %0d acks want 0", seen); end
    resp_delay = 0;
    req = 4'b0101;
    push(rr(req, lg_model), 1'b0, 0);
    wait_ack(200, to);
    e = sb.pop_front();
    checks++; if (to || ack !== 4'(1 << e.idx) || e.idx !== 0)
      begin errors++; $display("FAIL midrst_first_winner: got ack=%0h want 1", ack); end
    req = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_len_err();
    test_round_robin();
    test_tx_err();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
